// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: IF/ID inputs, register-file read/write-back taps, and the
// registered EX-slot outputs. The master modport drives the ID side; the slave
// modport belongs to id_ex_stage.
interface id_ex_stage_if #(
   parameter int unsigned XLEN = 32
);
   // ID side
   logic [31:0]     instr_d;
   logic [XLEN-1:0] pc_d;
   logic            valid_d;
   logic            flush_e;
   // register_file read data and address
   logic [XLEN-1:0] RD1;
   logic [XLEN-1:0] RD2;
   logic [4:0]      A1;
   logic [4:0]      A2;
   // write-back port as seen by register_file
   logic            WE3_w;
   logic [4:0]      A3_w;
   logic [XLEN-1:0] WD3_w;
   // hazard
   logic            stall_d;
   // EX slot
   logic            valid_e;
   logic [XLEN-1:0] pc_e;
   logic [XLEN-1:0] rd1_e;
   logic [XLEN-1:0] rd2_e;
   logic [XLEN-1:0] imm_e;
   logic [4:0]      rs1_e;
   logic [4:0]      rs2_e;
   logic [4:0]      rd_e;
   logic [2:0]      funct3_e;
   logic            funct7b5_e;
   logic            alu_src_e;
   logic            reg_write_e;
   logic            mem_read_e;
   logic            mem_write_e;
   logic            branch_e;
   logic            jump_e;

   modport master (
      output instr_d, pc_d, valid_d, flush_e, RD1, RD2, WE3_w, A3_w, WD3_w,
      input  A1, A2, stall_d, valid_e, pc_e, rd1_e, rd2_e, imm_e, rs1_e, rs2_e, rd_e,
             funct3_e, funct7b5_e, alu_src_e, reg_write_e, mem_read_e, mem_write_e,
             branch_e, jump_e
   );

   modport slave (
      input  instr_d, pc_d, valid_d, flush_e, RD1, RD2, WE3_w, A3_w, WD3_w,
      output A1, A2, stall_d, valid_e, pc_e, rd1_e, rd2_e, imm_e, rs1_e, rs2_e, rd_e,
             funct3_e, funct7b5_e, alu_src_e, reg_write_e, mem_read_e, mem_write_e,
             branch_e, jump_e
   );
endinterface

// File: rtl/id_ex_stage.sv
// RISC-V decode-to-execute stage: register-file addressing, RV32I decode,
// immediate generation, load-use hazard detection and the ID/EX register.
// Optional feature: define ID_WB_BYPASS_EN to capture write-back data directly
// when the register file has no write-to-read bypass.
module id_ex_stage #(
   parameter int unsigned XLEN      = 32,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input logic         clk,
   input logic         rst,
   id_ex_stage_if.slave bus
);

   localparam logic [6:0] OpR      = 7'b0110011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [2:0]      funct3;
      logic            funct7b5;
      logic            alu_src;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            branch;
      logic            jump;
   } ex_t;

   logic [31:0]        instr;
   logic [6:0]         opcode;
   logic [4:0]         rs1;
   logic [4:0]         rs2;
   logic [4:0]         rd;
   logic signed [31:0] imm32;
   logic               writes_rd;
   logic               uses_rs1;
   logic               uses_rs2;
   logic               alu_src;
   logic               mem_read;
   logic               mem_write;
   logic               branch;
   logic               jump;
   logic [XLEN-1:0]    op1;
   logic [XLEN-1:0]    op2;
   logic               stall;
   ex_t                ex_d;
   ex_t                ex_q;

   assign instr  = bus.instr_d;
   assign opcode = instr[6:0];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign rd     = instr[11:7];

   assign bus.A1 = rs1;
   assign bus.A2 = rs2;

   // Opcode decode: control bits, immediate format and register usage
   always_comb begin
      imm32     = '0;
      writes_rd = 1'b0;
      uses_rs1  = 1'b1;
      uses_rs2  = 1'b0;
      alu_src   = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      branch    = 1'b0;
      jump      = 1'b0;
      case (opcode)
         OpR: begin
            writes_rd = 1'b1;
            uses_rs2  = 1'b1;
         end
         OpImm: begin
            writes_rd = 1'b1;
            alu_src   = 1'b1;
            imm32     = {{20{instr[31]}}, instr[31:20]};
         end
         OpLoad: begin
            writes_rd = 1'b1;
            mem_read  = 1'b1;
            alu_src   = 1'b1;
            imm32     = {{20{instr[31]}}, instr[31:20]};
         end
         OpStore: begin
            mem_write = 1'b1;
            alu_src   = 1'b1;
            uses_rs2  = 1'b1;
            imm32     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         end
         OpBranch: begin
            branch   = 1'b1;
            uses_rs2 = 1'b1;
            imm32    = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         end
         OpJal: begin
            jump      = 1'b1;
            writes_rd = 1'b1;
            uses_rs1  = 1'b0;
            imm32     = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         OpJalr: begin
            jump      = 1'b1;
            writes_rd = 1'b1;
            imm32     = {{20{instr[31]}}, instr[31:20]};
         end
         OpLui, OpAuipc: begin
            writes_rd = 1'b1;
            alu_src   = 1'b1;
            uses_rs1  = 1'b0;
            imm32     = {instr[31:12], 12'h000};
         end
         default: ;
      endcase
      // The canonical NOP reads x0, so it can never take part in a load-use stall
      if (instr == NOP_INSTR) begin
         uses_rs1 = 1'b0;
      end
   end

`ifdef ID_WB_BYPASS_EN
   logic byp1;
   logic byp2;
   assign byp1 = bus.WE3_w && (bus.A3_w != 5'd0) && (bus.A3_w == rs1);
   assign byp2 = bus.WE3_w && (bus.A3_w != 5'd0) && (bus.A3_w == rs2);
   assign op1  = (rs1 == 5'd0) ? '0 : (byp1 ? bus.WD3_w : bus.RD1);
   assign op2  = (rs2 == 5'd0) ? '0 : (byp2 ? bus.WD3_w : bus.RD2);
`else
   // Register file is write-first, so the write-back port is not needed here
   logic unused_wb;
   assign unused_wb = ^{bus.WE3_w, bus.A3_w, bus.WD3_w};
   assign op1       = (rs1 == 5'd0) ? '0 : bus.RD1;
   assign op2       = (rs2 == 5'd0) ? '0 : bus.RD2;
`endif

   // Load-use hazard against the instruction currently in EX
   assign stall = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && bus.valid_d &&
                  (((ex_q.rd == rs1) && uses_rs1) || ((ex_q.rd == rs2) && uses_rs2));
   assign bus.stall_d = stall;

   // Next EX slot: bubble on flush or stall, otherwise the decoded ID fields
   always_comb begin
      ex_d = '0;
      if (!bus.flush_e && !stall) begin
         ex_d.valid     = bus.valid_d;
         ex_d.pc        = bus.pc_d;
         ex_d.rd1       = op1;
         ex_d.rd2       = op2;
         ex_d.imm       = XLEN'(imm32);
         ex_d.rs1       = rs1;
         ex_d.rs2       = rs2;
         ex_d.rd        = writes_rd ? rd : 5'd0;
         ex_d.funct3    = instr[14:12];
         ex_d.funct7b5  = instr[30];
         ex_d.alu_src   = alu_src;
         ex_d.reg_write = writes_rd && (rd != 5'd0);
         ex_d.mem_read  = mem_read;
         ex_d.mem_write = mem_write;
         ex_d.branch    = branch;
         ex_d.jump      = jump;
      end
   end

   // ID/EX pipeline register; reset leaves an empty EX slot
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_q <= '0;
      end else begin
         ex_q <= ex_d;
      end
   end

   assign bus.valid_e     = ex_q.valid;
   assign bus.pc_e        = ex_q.pc;
   assign bus.rd1_e       = ex_q.rd1;
   assign bus.rd2_e       = ex_q.rd2;
   assign bus.imm_e       = ex_q.imm;
   assign bus.rs1_e       = ex_q.rs1;
   assign bus.rs2_e       = ex_q.rs2;
   assign bus.rd_e        = ex_q.rd;
   assign bus.funct3_e    = ex_q.funct3;
   assign bus.funct7b5_e  = ex_q.funct7b5;
   assign bus.alu_src_e   = ex_q.alu_src;
   assign bus.reg_write_e = ex_q.reg_write;
   assign bus.mem_read_e  = ex_q.mem_read;
   assign bus.mem_write_e = ex_q.mem_write;
   assign bus.branch_e    = ex_q.branch;
   assign bus.jump_e      = ex_q.jump;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage. The driver applies one ID vector per
// cycle and pushes the hand-computed EX slot it expects after the next edge;
// a monitor pops and compares after every rising edge.
module tb_id_ex_stage;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic        funct7b5;
      logic        alu_src;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        jump;
   } exp_t;

   logic   clk;
   logic   rst;
   int     checks;
   int     errors;
   exp_t   exp_q[$];
   string  name_q[$];

   id_ex_stage_if #(.XLEN(32)) bus ();

   id_ex_stage #(.XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef ID_WB_BYPASS_EN
   localparam logic [31:0] BypRd1 = 32'hDEADBEEF;
`else
   localparam logic [31:0] BypRd1 = 32'h00001111;
`endif

   function automatic exp_t mk(logic v, logic [31:0] pc, logic [31:0] r1, logic [31:0] r2,
                               logic [31:0] imm, logic [4:0] s1, logic [4:0] s2,
                               logic [4:0] d, logic [2:0] f3, logic f7, logic alu,
                               logic rw, logic mr, logic mw, logic br, logic j);
      return '{v, pc, r1, r2, imm, s1, s2, d, f3, f7, alu, rw, mr, mw, br, j};
   endfunction

   function automatic exp_t cur();
      return '{bus.valid_e, bus.pc_e, bus.rd1_e, bus.rd2_e, bus.imm_e, bus.rs1_e, bus.rs2_e,
               bus.rd_e, bus.funct3_e, bus.funct7b5_e, bus.alu_src_e, bus.reg_write_e,
               bus.mem_read_e, bus.mem_write_e, bus.branch_e, bus.jump_e};
   endfunction

   task automatic chk(string name, logic [255:0] got, logic [255:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   // Apply one ID vector, check combinational outputs, queue the expected EX slot
   task automatic step(string name, logic [31:0] instr, logic [31:0] pc, logic vd,
                       logic fl, logic [31:0] r1, logic [31:0] r2, logic we,
                       logic [4:0] a3, logic [31:0] wd, logic [4:0] ea1, logic [4:0] ea2,
                       logic estall, exp_t e);
      bus.instr_d = instr;
      bus.pc_d    = pc;
      bus.valid_d = vd;
      bus.flush_e = fl;
      bus.RD1     = r1;
      bus.RD2     = r2;
      bus.WE3_w   = we;
      bus.A3_w    = a3;
      bus.WD3_w   = wd;
      #1;
      chk({name, ".A1"}, 256'(bus.A1), 256'(ea1));
      chk({name, ".A2"}, 256'(bus.A2), 256'(ea2));
      chk({name, ".stall_d"}, 256'(bus.stall_d), 256'(estall));
      exp_q.push_back(e);
      name_q.push_back(name);
      @(negedge clk);
   endtask

   // Monitor: compare the EX slot presented after each rising edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            chk({n, ".ex"}, 256'(cur()), 256'(e));
         end
      end
   end

   initial begin
      exp_t bub;
      bub    = '0;
      checks = 0;
      errors = 0;
      rst    = 1'b0;
      bus.instr_d = '0;
      bus.pc_d    = '0;
      bus.valid_d = 1'b0;
      bus.flush_e = 1'b0;
      bus.RD1     = '0;
      bus.RD2     = '0;
      bus.WE3_w   = 1'b0;
      bus.A3_w    = '0;
      bus.WD3_w   = '0;

      // Reset held with random inputs: EX slot and stall stay zero
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.instr_d = $urandom;
         bus.pc_d    = $urandom;
         bus.valid_d = 1'($urandom_range(0, 1));
         bus.flush_e = 1'($urandom_range(0, 1));
         bus.RD1     = $urandom;
         bus.RD2     = $urandom;
         bus.WE3_w   = 1'($urandom_range(0, 1));
         bus.A3_w    = 5'($urandom);
         bus.WD3_w   = $urandom;
         #1;
         chk("reset.ex", 256'(cur()), 256'(bub));
         chk("reset.stall_d", 256'(bus.stall_d), 256'(1'b0));
      end
      @(negedge clk);
      rst = 1'b1;

      // addi x5,x1,-4
      step("addi", 32'hFFC08293, 32'h100, 1, 0, 32'd10, 32'h4D, 0, 0, 0, 5'd1, 5'd28, 0,
           mk(1, 32'h100, 32'hA, 32'h4D, 32'hFFFFFFFC, 1, 28, 5, 0, 1, 1, 1, 0, 0, 0, 0));
      // lw x3,0(x2)
      step("lw_x3", 32'h00012183, 32'h104, 1, 0, 32'h2000, 32'h5, 0, 0, 0, 5'd2, 5'd0, 0,
           mk(1, 32'h104, 32'h2000, 32'h0, 32'h0, 2, 0, 3, 2, 0, 1, 1, 1, 0, 0, 0));
      // add x4,x3,x1 behind the load: one bubble, then captured
      step("add_stall", 32'h00118233, 32'h108, 1, 0, 32'h30, 32'h11, 0, 0, 0, 5'd3, 5'd1, 1,
           bub);
      step("add", 32'h00118233, 32'h108, 1, 0, 32'h30, 32'h11, 0, 0, 0, 5'd3, 5'd1, 0,
           mk(1, 32'h108, 32'h30, 32'h11, 32'h0, 3, 1, 4, 0, 0, 0, 1, 0, 0, 0, 0));
      // lw x6,4(x2)
      step("lw_x6", 32'h00412303, 32'h10C, 1, 0, 32'h2000, 32'h99, 0, 0, 0, 5'd2, 5'd4, 0,
           mk(1, 32'h10C, 32'h2000, 32'h99, 32'h4, 2, 4, 6, 2, 0, 1, 1, 1, 0, 0, 0));
      // sw x6,8(x7) with flush and load-use together: bubble
      step("sw_flush", 32'h0063A423, 32'h110, 1, 1, 32'h3000, 32'h55, 0, 0, 0, 5'd7, 5'd6, 1,
           bub);
      step("sw", 32'h0063A423, 32'h110, 1, 0, 32'h3000, 32'h55, 0, 0, 0, 5'd7, 5'd6, 0,
           mk(1, 32'h110, 32'h3000, 32'h55, 32'h8, 7, 6, 0, 2, 0, 1, 0, 0, 1, 0, 0));
      // beq x1,x2,-8
      step("beq", 32'hFE208CE3, 32'h114, 1, 0, 32'h1, 32'h2, 0, 0, 0, 5'd1, 5'd2, 0,
           mk(1, 32'h114, 32'h1, 32'h2, 32'hFFFFFFF8, 1, 2, 0, 0, 1, 0, 0, 0, 0, 1, 0));
      // jal x1,+2048 (rs1 field is x0, so rd1_e reads as zero)
      step("jal", 32'h001000EF, 32'h118, 1, 0, 32'h12, 32'h34, 0, 0, 0, 5'd0, 5'd1, 0,
           mk(1, 32'h118, 32'h0, 32'h34, 32'h800, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1));
      // addi x10,x9,0 while write-back targets x9
      step("wb_x9", 32'h00048513, 32'h11C, 1, 0, 32'h1111, 32'h0, 1, 5'd9, 32'hDEADBEEF,
           5'd9, 5'd0, 0,
           mk(1, 32'h11C, BypRd1, 32'h0, 32'h0, 9, 0, 10, 0, 0, 1, 1, 0, 0, 0, 0));
      // same with write-back to x0: never bypassed
      step("wb_x0", 32'h00048513, 32'h120, 1, 0, 32'h0, 32'h0, 1, 5'd0, 32'hDEADBEEF,
           5'd9, 5'd0, 0,
           mk(1, 32'h120, 32'h0, 32'h0, 32'h0, 9, 0, 10, 0, 0, 1, 1, 0, 0, 0, 0));
      // drain with a flushed NOP
      step("drain", 32'h00000013, 32'h124, 0, 1, 32'h0, 32'h0, 0, 0, 0, 5'd0, 5'd0, 0, bub);

      @(negedge clk);
      @(negedge clk);
      chk("queue_empty", 256'(exp_q.size()), 256'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
